cve2_mem_arbiter: RTL and testbench
===================================

# cve2_mem_arbiter

Memory-side companion to the core top level. It accepts the core's instruction-fetch and data request/grant/rvalid ports and merges them onto one single-port SRAM with fixed 1-cycle read latency. Arbitration is round-robin. Out-of-range accesses are answered with a bus error. It gives small integrations (simulation tops, FPGA bring-up, tightly coupled scratchpad) a working memory system without an external interconnect.

## Interface
- MemSizeBytes, 65536, SRAM size in bytes; power of two, >= 8
- BaseAddr, 32'h0000_0000, SRAM base address; aligned to MemSizeBytes
- MemAddrW, derived = clog2(MemSizeBytes/4), SRAM word-address width

Ports. One clock; reset is synchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_addr_i  in  32  fetch byte address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  read data
- data_err_o  out  1  data bus error
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MemAddrW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o

## Operation
- At most one grant per cycle. Grants are combinational from the requests in the same cycle. Both grants are forced to 0 while rst_ni = 0.
- Arbitration:
  - Only one requester: that requester is granted.
  - Both requesting: the port not granted last wins.
  - The last_grant_q register updates only on a grant.
  - Reset value of last_grant_q = DATA, so the first tie goes to the instruction port.
- Range check: the request is in range when (addr − BaseAddr) < MemSizeBytes, computed as unsigned 32-bit.
  - Address wrap below BaseAddr is out of range.
  - addr == BaseAddr+MemSizeBytes is out of range.
- Granted and in range:
  - mem_req_o = 1.
  - mem_addr_o = (addr − BaseAddr)[MemAddrW+1:2].
  - Instruction port: mem_we_o = 0 and mem_be_o = 4'hF.
  - Data port: mem_we_o, mem_be_o and mem_wdata_o come from the data port.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are 0 when mem_req_o = 0.
- Granted but out of range: mem_req_o = 0, and an error response is scheduled.
- A write with data_be_i = 0 still issues mem_req_o with mem_be_o = 0.
- Response pipeline registers: rsp_valid_q, rsp_port_q (INSTR/DATA), rsp_err_q, rsp_read_q.
  - These are loaded on every grant and cleared when there is no grant.
  - The response appears exactly one cycle after the grant, on the granted port only.
- Response data:
  - rdata = mem_rdata_i when rsp_read_q & ~rsp_err_q, else 32'h0.
  - err = rsp_err_q.
  - rdata and err are 0 whenever the corresponding rvalid is 0.
- Writes always produce rvalid with rdata = 0.
- Address bits [1:0] are ignored. Misalignment is handled upstream.

## Timing
- Reset (edge with rst_ni = 0):
  - All registers cleared. All rvalid, rdata and err outputs are 0 from the following cycle.
  - mem_req_o = 0 and both grants = 0 while rst_ni is low.
- Latency: grant in cycle N, response in cycle N+1, fixed with no stalls.
- Throughput: one access per cycle. Alternating tie-break gives each port 50 % under continuous contention.
- Reset mid-operation: a response pending from cycle N−1 is dropped if rst_ni = 0 at the edge. No rvalid appears for it. The SRAM may have completed a write and that is acceptable.
- Simultaneous grant on one port and response on the other in the same cycle is legal and must be handled.

## Test plan
- Single instruction fetch at 0x0000_0010 with SRAM word 4 = 0xDEADBEEF:
  - instr_gnt_o = 1 in cycle N with mem_addr_o = 4.
  - instr_rvalid_o = 1 with rdata 0xDEADBEEF and err 0 in N+1.
- Data write then read:
  - Write addr 0x20, be = 4'b0011, wdata = 0x12345678, then read addr 0x20 from an SRAM preset to 0xAAAAAAAA.
  - Read returns 0xAAAA5678.
  - Both accesses produce data_rvalid_o one cycle after their grant.
- Contention:
  - Both ports request continuously for 6 cycles after reset.
  - Grant sequence must be I, D, I, D, I, D, with responses following one cycle later on the matching port.
- Out of range (MemSizeBytes = 65536, BaseAddr = 0):
  - Data read at 0x0001_0000 gives gnt = 1 and mem_req_o = 0, then data_rvalid_o = 1, data_err_o = 1, rdata = 0 next cycle.
  - Address 0x0000_FFFC succeeds without error.
- Reset mid-operation:
  - Grant a read in cycle N, assert rst_ni = 0 at the N→N+1 edge.
  - No rvalid in N+1, all outputs 0.
  - The first tie after release grants the instruction port.
- Back-to-back with a response collision:
  - Data read granted in N, instruction fetch granted in N+1.
  - data_rvalid_o in N+1 and instr_rvalid_o in N+2, with each rdata routed to the correct port and never to both.

Source files
------------

// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter merging the core's instruction-fetch and data ports onto one
// single-port SRAM with fixed 1-cycle read latency. Out-of-range accesses get an error response.
module cve2_mem_arbiter #(
  parameter int unsigned MemSizeBytes = 65536,
  parameter logic [31:0] BaseAddr     = 32'h0000_0000,
  parameter int unsigned MemAddrW     = $clog2(MemSizeBytes / 4)
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                instr_req_i,
  output logic                instr_gnt_o,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,

  input  logic                data_req_i,
  output logic                data_gnt_o,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_rvalid_o,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [MemAddrW-1:0] mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic [31:0]         mem_rdata_i
);

  typedef enum logic {
    PortInstr = 1'b0,
    PortData  = 1'b1
  } port_e;

  port_e       r_last_grant;
  logic        r_rsp_valid;
  port_e       r_rsp_port;
  logic        r_rsp_err;
  logic        r_rsp_read;

  logic        w_instr_gnt;
  logic        w_data_gnt;
  logic        w_gnt;
  logic [31:0] w_addr;
  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_rsp_ok;

  // Grant selection: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (rst_ni) begin
      w_instr_gnt = instr_req_i & (~data_req_i | (r_last_grant == PortData));
      w_data_gnt  = data_req_i & (~instr_req_i | (r_last_grant == PortInstr));
    end
  end

  assign w_gnt       = w_instr_gnt | w_data_gnt;
  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;

  // Range check on the granted address; the unsigned subtraction makes addresses below
  // BaseAddr wrap to huge offsets, which fail the compare.
  always_comb begin
    w_addr     = w_data_gnt ? data_addr_i : instr_addr_i;
    w_off      = w_addr - BaseAddr;
    w_in_range = (w_off < MemSizeBytes);
  end

  // SRAM request drive; all fields held at zero when no access is issued.
  always_comb begin
    mem_req_o   = w_gnt & w_in_range;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_addr_o = w_off[MemAddrW+1:2];
      if (w_data_gnt) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
      end
    end
  end

  // Arbitration history and response pipeline; a pending response is dropped on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_grant <= PortData;
      r_rsp_valid  <= 1'b0;
      r_rsp_port   <= PortInstr;
      r_rsp_err    <= 1'b0;
      r_rsp_read   <= 1'b0;
    end else if (w_gnt) begin
      r_last_grant <= w_data_gnt ? PortData : PortInstr;
      r_rsp_valid  <= 1'b1;
      r_rsp_port   <= w_data_gnt ? PortData : PortInstr;
      r_rsp_err    <= ~w_in_range;
      r_rsp_read   <= w_instr_gnt | ~data_we_i;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_port   <= PortInstr;
      r_rsp_err    <= 1'b0;
      r_rsp_read   <= 1'b0;
    end
  end

  assign w_rsp_ok = r_rsp_read & ~r_rsp_err;

  // Route the single response to the port that was granted; other port sees all zeros.
  always_comb begin
    instr_rvalid_o = r_rsp_valid & (r_rsp_port == PortInstr);
    data_rvalid_o  = r_rsp_valid & (r_rsp_port == PortData);
    instr_err_o    = instr_rvalid_o & r_rsp_err;
    data_err_o     = data_rvalid_o & r_rsp_err;
    instr_rdata_o  = (instr_rvalid_o & w_rsp_ok) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o & w_rsp_ok) ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed bench for cve2_mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_cve2_mem_arbiter;

  localparam int unsigned MemAddrW = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]         instr_addr, instr_rdata;
  logic                data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]          data_be;
  logic [31:0]         data_addr, data_wdata, data_rdata;
  logic                mem_req, mem_we;
  logic [3:0]          mem_be;
  logic [MemAddrW-1:0] mem_addr;
  logic [31:0]         mem_wdata, mem_rdata;

  logic [31:0]         sram [16384];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cve2_mem_arbiter #(
    .MemSizeBytes(65536),
    .BaseAddr    (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_req_i   (instr_req),
    .instr_gnt_o   (instr_gnt),
    .instr_addr_i  (instr_addr),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .instr_err_o   (instr_err),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_be_o      (mem_be),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  // SRAM model: byte-masked write, registered read data.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
  endtask

  task automatic drive_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
    sram[4]     = 32'hDEADBEEF;
    sram[8]     = 32'hAAAAAAAA;
    sram[16383] = 32'h0BADF00D;
    mem_rdata   = 32'h0;

    // Reset with both ports requesting: grants and SRAM strobe forced low.
    idle();
    rst_n      = 1'b0;
    instr_req  = 1'b1;
    data_req   = 1'b1;
    #2;
    check("rst_instr_gnt", {31'b0, instr_gnt}, 32'd0);
    check("rst_data_gnt", {31'b0, data_gnt}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    cyc();
    cyc();
    check("rst_rvalids", {30'b0, instr_rvalid, data_rvalid}, 32'd0);
    check("rst_errs", {30'b0, instr_err, data_err}, 32'd0);
    idle();
    rst_n = 1'b1;
    cyc();

    // Single fetch from 0x10.
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    check("fetch_gnt", {30'b0, instr_gnt, data_gnt}, 32'h2);
    check("fetch_mem_req", {31'b0, mem_req}, 32'd1);
    check("fetch_mem_addr", {18'b0, mem_addr}, 32'd4);
    check("fetch_we_be", {27'b0, mem_we, mem_be}, 32'h0F);
    cyc();
    idle();
    #1;
    check("fetch_rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'h2);
    check("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    check("fetch_err", {31'b0, instr_err}, 32'd0);
    cyc();

    // Partial write to 0x20.
    drive_data(1'b1, 4'b0011, 32'h20, 32'h12345678);
    #1;
    check("wr_gnt", {30'b0, instr_gnt, data_gnt}, 32'h1);
    check("wr_mem_addr", {18'b0, mem_addr}, 32'd8);
    check("wr_we_be", {27'b0, mem_we, mem_be}, 32'h13);
    check("wr_wdata", mem_wdata, 32'h12345678);
    cyc();
    // Read back 0x20 while the write response is out.
    idle();
    drive_data(1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    check("wr_rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'h1);
    check("wr_rdata", data_rdata, 32'h0);
    check("rd_gnt", {30'b0, instr_gnt, data_gnt}, 32'h1);
    check("rd_we", {31'b0, mem_we}, 32'd0);
    cyc();
    // Fetch granted while the data read response is returned.
    idle();
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    check("b2b_fetch_gnt", {30'b0, instr_gnt, data_gnt}, 32'h2);
    check("b2b_rd_rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'h1);
    check("b2b_rd_rdata", data_rdata, 32'hAAAA5678);
    check("b2b_rd_instr_rdata", instr_rdata, 32'h0);
    cyc();
    idle();
    #1;
    check("b2b_fetch_rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'h2);
    check("b2b_fetch_rdata", instr_rdata, 32'hDEADBEEF);
    check("b2b_fetch_data_rdata", data_rdata, 32'h0);
    cyc();

    // Out of range, one past the end.
    drive_data(1'b0, 4'hF, 32'h0001_0000, 32'h0);
    #1;
    check("oor_gnt", {31'b0, data_gnt}, 32'd1);
    check("oor_mem_req", {31'b0, mem_req}, 32'd0);
    check("oor_mem_addr", {18'b0, mem_addr}, 32'd0);
    cyc();
    // Last in-range word issued while the error response is out.
    drive_data(1'b0, 4'hF, 32'h0000_FFFC, 32'h0);
    #1;
    check("oor_rsp", {29'b0, data_rvalid, data_err, instr_rvalid}, 32'h6);
    check("oor_rdata", data_rdata, 32'h0);
    check("top_mem_req", {31'b0, mem_req}, 32'd1);
    check("top_mem_addr", {18'b0, mem_addr}, 32'd16383);
    cyc();
    idle();
    #1;
    check("top_rsp", {30'b0, data_rvalid, data_err}, 32'h2);
    check("top_rdata", data_rdata, 32'h0BADF00D);
    cyc();

    // Reset just after a fetch grant: its response must vanish.
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    #1;
    check("mid_rst_gnt", {31'b0, instr_gnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    cyc();
    idle();
    #1;
    check("mid_rst_rvalid", {30'b0, instr_rvalid, data_rvalid}, 32'h0);
    check("mid_rst_rdata", instr_rdata | data_rdata, 32'h0);
    check("mid_rst_err", {30'b0, instr_err, data_err}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Continuous contention after reset: I, D, I, D, I, D.
    instr_req  = 1'b1;
    instr_addr = 32'h10;
    drive_data(1'b0, 4'hF, 32'h20, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("cont_gnt_%0d", k), {30'b0, instr_gnt, data_gnt},
            (k % 2 == 0) ? 32'h2 : 32'h1);
      if (k > 0) begin
        check($sformatf("cont_rsp_%0d", k), {30'b0, instr_rvalid, data_rvalid},
              (k % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("cont_rdata_%0d", k), instr_rdata | data_rdata,
              (k % 2 == 0) ? 32'hAAAA5678 : 32'hDEADBEEF);
      end
      cyc();
    end
    idle();
    #1;
    check("cont_last_rsp", {30'b0, instr_rvalid, data_rvalid}, 32'h1);
    check("cont_last_rdata", data_rdata, 32'hAAAA5678);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
